// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding and counter-width function.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// 1-bit combinational full-subtractor cell: x - y - borrow_in.
// Ports: diff, borrow_out (out); x, y, borrow_in (in).
module full_subtractor (
  output logic diff,
  output logic borrow_out,
  input  logic x,
  input  logic y,
  input  logic borrow_in
);

  assign diff       = x ^ y ^ borrow_in;
  assign borrow_out = (~x & y) | (~(x ^ y) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: diff = a - b - borrow_in.
// Ports: clk, rst_n, start, a, b, borrow_in; busy, done, diff, borrow_out.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             busy_q, done_q;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] res_sh;

  full_subtractor u_cell (
    .diff       (cell_d),
    .borrow_out (cell_bo),
    .x          (a_sh_q[0]),
    .y          (b_sh_q[0]),
    .borrow_in  (brw_q)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place.
  if (WIDTH == 1) begin : g_w1
    assign res_sh = cell_d;
  end else begin : g_wn
    assign res_sh = {cell_d, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = borrow_in;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_sh;
        brw_d  = cell_bo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = res_sh;
          bout_d  = cell_bo;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      // Flags come straight from flops, decoded from next state.
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Hand-computed expected results, one check task.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8, bi8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;

  logic       start1, bi1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;

  int n_chk;
  int n_err;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .borrow_in  (bi8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (bo8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .borrow_in  (bi1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (bo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Launch one 8-bit op; optionally poke a stray start in RUN cycle 3.
  task automatic run8(input string tag,
                      input logic [7:0] ia,
                      input logic [7:0] ib,
                      input logic ibi,
                      input logic [7:0] ed,
                      input logic eb,
                      input bit inj);
    int nb;
    bit seen;
    @(negedge clk);
    a8 = ia; b8 = ib; bi8 = ibi; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'h5A; b8 = 8'hC3; bi8 = 1'b1;
    nb = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
      else if (busy8) nb++;
      if (inj && c == 3) begin
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      end else begin
        start8 = 1'b0;
      end
    end
    chk({tag, ".busy_cycles"}, 32'(nb), 32'd8);
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".diff"}, 32'(diff8), 32'(ed));
    chk({tag, ".borrow"}, 32'(bo8), 32'(eb));
    @(negedge clk);
    chk({tag, ".done_fall"}, 32'(done8), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy8), 32'd0);
  endtask

  logic [7:0] d_tab;
  logic [7:0] bo_tab;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;
    // Bit i = result for {x,y,bi} = i.
    d_tab  = 8'b1001_0110;
    bo_tab = 8'b1000_1110;

    #2;
    chk("rst.busy", 32'(busy8), 32'd0);
    chk("rst.done", 32'(done8), 32'd0);
    chk("rst.diff", 32'(diff8), 32'd0);
    chk("rst.borrow", 32'(bo8), 32'd0);
    #20;
    rst_n = 1'b1;

    run8("t100_37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
    run8("t5_9", 8'd5, 8'd9, 1'b0, 8'hFC, 1'b1, 1'b0);
    run8("t0_1", 8'd0, 8'd1, 1'b0, 8'hFF, 1'b1, 1'b0);
    run8("t255_255_1", 8'd255, 8'd255, 1'b1, 8'hFF, 1'b1, 1'b0);
    run8("t0_0", 8'd0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    run8("inject", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold.diff", 32'(diff8), 32'd63);
      chk("hold.busy", 32'(busy8), 32'd0);
    end

    // Asynchronous reset in the middle of RUN cycle 4.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd37; bi8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    chk("arst.pre_busy", 32'(busy8), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy8), 32'd0);
    chk("arst.done", 32'(done8), 32'd0);
    chk("arst.diff", 32'(diff8), 32'd0);
    chk("arst.borrow", 32'(bo8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8("t10_3", 8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 1'b0);

    // WIDTH=1: full truth table of the cell.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = i[2]; b1 = i[1]; bi1 = i[0]; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      @(negedge clk);
      chk($sformatf("w1_%0d.busy", i), 32'(busy1), 32'd1);
      chk($sformatf("w1_%0d.early", i), 32'(done1), 32'd0);
      @(negedge clk);
      chk($sformatf("w1_%0d.done", i), 32'(done1), 32'd1);
      chk($sformatf("w1_%0d.diff", i), 32'(diff1), 32'(d_tab[i]));
      chk($sformatf("w1_%0d.borrow", i), 32'(bo1), 32'(bo_tab[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
